// File: rtl/rgb_color_sel_pkg.sv
// rgb_pkg: colour codes, selector states and ms-to-cycles helper for rgb_color_sel
package rgb_pkg;
   localparam logic [2:0] RGB_OFF   = 3'd0;
   localparam logic [2:0] RGB_RED   = 3'd1;
   localparam logic [2:0] RGB_GREEN = 3'd2;
   localparam logic [2:0] RGB_BLUE  = 3'd4;
   localparam logic [2:0] RGB_WHITE = 3'd7;
   typedef enum logic [1:0] {IDLE, SHOW_ERR, SHOW_OK} sel_state_t;
   function automatic int ms_to_cycles(input int clk_hz, input int ms);
      return (clk_hz / 1000) * ms;
   endfunction
endpackage

// File: rtl/rgb_color_sel_debounce.sv
// btn_debounce: 2-FF sync, debounce, press pulse; long-press pulse under RGB_SEL_LONGPRESS_EN
module btn_debounce #(
   parameter int DB_CYCLES = 4
`ifdef RGB_SEL_LONGPRESS_EN
   , parameter int LONG_CYCLES = 20
`endif
) (
   input  logic clk_in,
   input  logic reset,
   input  logic btn_in,
   output logic press,
   output logic long_press
);
   localparam int DW = $clog2(DB_CYCLES + 1);
   logic s1, s2, level;
   logic [DW-1:0] cnt;
   always_ff @(posedge clk_in) begin
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         level <= 1'b0;
         cnt <= '0;
         press <= 1'b0;
      end else begin
         s1 <= btn_in;
         s2 <= s1;
         press <= 1'b0;
         if (s2 == level) cnt <= '0;
         else if (cnt == DW'(DB_CYCLES)) begin
            level <= s2;
            cnt <= '0;
            press <= s2;
         end else cnt <= cnt + 1'b1;
      end
   end
`ifdef RGB_SEL_LONGPRESS_EN
   localparam int LW = $clog2(LONG_CYCLES + 1);
   logic [LW-1:0] lcnt;
   // counter saturates so the clear fires once per hold
   always_ff @(posedge clk_in) begin
      if (reset) begin
         lcnt <= '0;
         long_press <= 1'b0;
      end else begin
         lcnt <= !level ? '0 : (lcnt != LW'(LONG_CYCLES)) ? lcnt + 1'b1 : lcnt;
         long_press <= level && lcnt == LW'(LONG_CYCLES - 1);
      end
   end
`else
   assign long_press = 1'b0;
`endif
endmodule

// File: rtl/rgb_color_sel.sv
// rgb_color_sel: button-stepped user colour with timed error/ok overrides; RGB_SEL_LONGPRESS_EN adds long-press clear
module rgb_color_sel
   import rgb_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 100000000,
   parameter int DEBOUNCE_MS = 20,
   parameter int HOLD_MS = 500
`ifdef RGB_SEL_LONGPRESS_EN
   , parameter int LONG_MS = 1000
`endif
) (
   input  logic       clk_in,
   input  logic       reset,
   input  logic       btn_in,
   input  logic       err_evt,
   input  logic       ok_evt,
   output logic [2:0] led_code,
   output logic       override
);
   localparam int DEBOUNCE_CYCLES = ms_to_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);
   localparam int HOLD_CYCLES = ms_to_cycles(CLK_FREQ_HZ, HOLD_MS);
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   logic press, long_press;
   logic [2:0] user_color;
   logic [HW-1:0] hold_cnt;
   sel_state_t state;
   btn_debounce #(
      .DB_CYCLES(DEBOUNCE_CYCLES)
`ifdef RGB_SEL_LONGPRESS_EN
      , .LONG_CYCLES(ms_to_cycles(CLK_FREQ_HZ, LONG_MS))
`endif
   ) u_btn (
      .clk_in(clk_in),
      .reset(reset),
      .btn_in(btn_in),
      .press(press),
      .long_press(long_press)
   );
   always_ff @(posedge clk_in) begin
      if (reset) begin
         state <= IDLE;
         hold_cnt <= '0;
         user_color <= RGB_OFF;
         led_code <= RGB_OFF;
         override <= 1'b0;
      end else begin
         user_color <= long_press ? RGB_OFF : press ? user_color + 3'd1 : user_color;
         if (err_evt) begin
            state <= SHOW_ERR;
            hold_cnt <= '0;
            led_code <= RGB_RED;
            override <= 1'b1;
         end else if (ok_evt && state != SHOW_ERR) begin
            state <= SHOW_OK;
            hold_cnt <= '0;
            led_code <= RGB_GREEN;
            override <= 1'b1;
         end else if (state == IDLE) led_code <= user_color;
         else if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
            state <= IDLE;
            hold_cnt <= '0;
            led_code <= user_color;
            override <= 1'b0;
         end else hold_cnt <= hold_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_rgb_color_sel.sv
// tb_rgb_color_sel: directed and random checks of rgb_color_sel against a cycle-level behavioural model
module tb_rgb_color_sel;
   localparam int DB = 4, HOLD = 10, LONG = 20;
   logic clk_in = 1'b0, reset = 1'b1, btn_in = 1'b0, err_evt = 1'b0, ok_evt = 1'b0;
   logic [2:0] led_code;
   logic override;
   int tests = 0, fails = 0;
   int bh0, bh1, lvl, run, held, press_q, long_q, color, mode, left, exp_led, exp_ov;

   rgb_color_sel #(
      .CLK_FREQ_HZ(1000),
      .DEBOUNCE_MS(4),
      .HOLD_MS(10)
`ifdef RGB_SEL_LONGPRESS_EN
      , .LONG_MS(20)
`endif
   ) dut (
      .clk_in(clk_in),
      .reset(reset),
      .btn_in(btn_in),
      .err_evt(err_evt),
      .ok_evt(ok_evt),
      .led_code(led_code),
      .override(override)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // mode: 0 user colour, 1 error shown, 2 ok shown; left = override cycles still to show
   task automatic model(input int b, input int e, input int o, input int r);
      int syn, rose, nlong;
      if (r != 0) begin
         bh0 = 0; bh1 = 0; lvl = 0; run = 0; held = 0; press_q = 0; long_q = 0;
         color = 0; mode = 0; left = 0; exp_led = 0; exp_ov = 0;
         return;
      end
      syn = bh1; bh1 = bh0; bh0 = b;
      if (e != 0) begin mode = 1; left = HOLD; end
      else if (o != 0 && mode != 1) begin mode = 2; left = HOLD; end
      else if (mode != 0) begin
         left--;
         if (left == 0) mode = 0;
      end
      exp_led = (mode == 1) ? 1 : (mode == 2) ? 2 : color;
      exp_ov = (mode != 0) ? 1 : 0;
      color = (long_q != 0) ? 0 : (press_q != 0) ? (color + 1) % 8 : color;
`ifdef RGB_SEL_LONGPRESS_EN
      held = (lvl != 0) ? held + 1 : 0;
      nlong = (held == LONG) ? 1 : 0;
`else
      nlong = 0;
`endif
      rose = 0;
      if (syn != lvl) begin
         run++;
         if (run > DB) begin lvl = syn; run = 0; rose = syn; end
      end else run = 0;
      press_q = rose;
      long_q = nlong;
   endtask

   task automatic tick(input logic b, input logic e, input logic o, input logic r);
      btn_in = b; err_evt = e; ok_evt = o; reset = r;
      @(posedge clk_in);
      model(int'(b), int'(e), int'(o), int'(r));
      #1;
      check("led_code", {29'd0, led_code}, exp_led);
      check("override", {31'd0, override}, exp_ov);
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic push(input int n);
      repeat (n) begin
         repeat (8) tick(1'b1, 1'b0, 1'b0, 1'b0);
         idle(8);
      end
   endtask

   initial begin
      int len;
      logic b;
      repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b1);
      check("reset_led", {29'd0, led_code}, 0);
      check("reset_ovr", {31'd0, override}, 0);
      idle(2);
      repeat (10) tick(1'b1, 1'b0, 1'b0, 1'b0);
      check("first_press", {29'd0, led_code}, 1);
      repeat (20) tick(1'b1, 1'b0, 1'b0, 1'b0);
      idle(10);
`ifdef RGB_SEL_LONGPRESS_EN
      check("held_30", {29'd0, led_code}, 0);
`else
      check("one_incr", {29'd0, led_code}, 1);
`endif
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) tick(((i / 2) % 2) != 0, 1'b0, 1'b0, 1'b0);
      idle(8);
      check("bounce", {29'd0, led_code}, 0);
      push(7);
      check("wrap_7", {29'd0, led_code}, 7);
      push(1);
      check("wrap_0", {29'd0, led_code}, 0);
      push(5);
      check("color_5", {29'd0, led_code}, 5);
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      check("err_red", {29'd0, led_code}, 1);
      check("err_ovr", {31'd0, override}, 1);
      idle(9);
      check("err_last", {29'd0, led_code}, 1);
      idle(1);
      check("err_done", {29'd0, led_code}, 5);
      check("err_ovr_off", {31'd0, override}, 0);
      tick(1'b0, 1'b1, 1'b1, 1'b0);
      check("both_red", {29'd0, led_code}, 1);
      idle(12);
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      check("ok_green", {29'd0, led_code}, 2);
      idle(3);
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      idle(9);
      check("ok_ext", {29'd0, led_code}, 2);
      idle(1);
      check("ok_done", {29'd0, led_code}, 5);
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      idle(2);
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      check("ok_to_err", {29'd0, led_code}, 1);
      idle(9);
      check("ok_to_err_hold", {29'd0, led_code}, 1);
      idle(1);
      check("ok_to_err_done", {29'd0, led_code}, 5);
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      idle(3);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      check("rst_err_led", {29'd0, led_code}, 0);
      check("rst_err_ovr", {31'd0, override}, 0);
      idle(1);
      repeat (4) tick(1'b1, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b1);
      check("rst_db_led", {29'd0, led_code}, 0);
      repeat (10) tick(1'b1, 1'b0, 1'b0, 1'b0);
      check("restabilise", {29'd0, led_code}, 1);
      idle(10);
`ifdef RGB_SEL_LONGPRESS_EN
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      push(3);
      check("long_start", {29'd0, led_code}, 3);
      repeat (12) tick(1'b1, 1'b0, 1'b0, 1'b0);
      check("long_short", {29'd0, led_code}, 4);
      repeat (18) tick(1'b1, 1'b0, 1'b0, 1'b0);
      check("long_clear", {29'd0, led_code}, 0);
      idle(10);
      check("long_release", {29'd0, led_code}, 0);
`endif
      b = 1'b0;
      for (int k = 0; k < 60; k++) begin
         b = ~b;
         len = (k % 3 == 0) ? $urandom_range(1, 3) : $urandom_range(5, 30);
         repeat (len) tick(b, $urandom_range(0, 39) == 0, $urandom_range(0, 24) == 0,
                           $urandom_range(0, 299) == 0);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
